// File: rtl/pwm_fade_pkg.sv
// Shared types and constants for the breathing-LED PWM fade controller.
package pwm_fade_pkg;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] PERIOD_LAST = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } fade_state_t;

endpackage

// File: rtl/pwm_duty_ramp.sv
// Saturating duty stepper: next duty for a rising or falling ramp plus end-of-ramp flags.
module pwm_duty_ramp
    import pwm_fade_pkg::*;
#(
    parameter logic [CNT_W-1:0] DUTY_MAX = 8'hFF
) (
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] step,
    output logic [CNT_W-1:0] duty_up,
    output logic [CNT_W-1:0] duty_down,
    output logic             at_max,
    output logic             at_zero
);

    logic [CNT_W:0] sum;
    logic [CNT_W:0] diff;

    // One spare bit catches both overflow past the ceiling and underflow below zero.
    always_comb begin
        sum       = {1'b0, duty} + {1'b0, step};
        diff      = {1'b0, duty} - {1'b0, step};
        duty_up   = (sum >= {1'b0, DUTY_MAX}) ? DUTY_MAX : sum[CNT_W-1:0];
        duty_down = diff[CNT_W] ? '0 : diff[CNT_W-1:0];
        at_max    = (duty_up == DUTY_MAX);
        at_zero   = (duty_down == '0);
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing-LED controller: ramps PWM duty up and down, changing only at period boundaries.
// Define PWM_FADE_HOLD_EN to add hold phases at the top and bottom of each ramp.
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter logic [CNT_W-1:0] DUTY_MAX = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             start,
    input  logic             stop,
    input  logic             loop,
    input  logic [CNT_W-1:0] step,
    input  logic [CNT_W-1:0] hold_periods,
    output logic             pwm_out,
    output logic [CNT_W-1:0] duty,
    output logic             busy,
    output logic             cycle_done
);

    fade_state_t      state;
    fade_state_t      state_next;
    logic [CNT_W-1:0] step_q;
    logic [CNT_W-1:0] duty_up;
    logic [CNT_W-1:0] duty_down;
    logic             period_end;
    logic             at_max;
    logic             at_zero;
    logic             cycle_end;

    assign period_end = (cnt == PERIOD_LAST);

    pwm_duty_ramp #(.DUTY_MAX(DUTY_MAX)) u_ramp (
        .duty      (duty),
        .step      (step_q),
        .duty_up   (duty_up),
        .duty_down (duty_down),
        .at_max    (at_max),
        .at_zero   (at_zero)
    );

`ifdef PWM_FADE_HOLD_EN
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_done;

    assign hold_done = period_end && (hold_cnt == '0);
`else
    logic [CNT_W-1:0] hold_periods_unused;

    assign hold_periods_unused = hold_periods;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // stop outranks everything, including a start in the same cycle.
    always_comb begin
        state_next = state;
        cycle_end  = 1'b0;
        if (stop) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_next = UP;
`ifdef PWM_FADE_HOLD_EN
                UP:      if (period_end && at_max)  state_next = HOLD_HI;
                HOLD_HI: if (hold_done)             state_next = DOWN;
                DOWN:    if (period_end && at_zero) state_next = HOLD_LO;
                HOLD_LO: if (hold_done) begin
                    cycle_end  = 1'b1;
                    state_next = loop ? UP : IDLE;
                end
`else
                UP:   if (period_end && at_max) state_next = DOWN;
                DOWN: if (period_end && at_zero) begin
                    cycle_end  = 1'b1;
                    state_next = loop ? UP : IDLE;
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty       <= '0;
            step_q     <= CNT_W'(1);
            pwm_out    <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            pwm_out    <= (cnt < duty);
            cycle_done <= cycle_end;
            if (stop) begin
                duty <= '0;
            end else if (state == IDLE) begin
                duty <= '0;
                if (start) step_q <= (step == '0) ? CNT_W'(1) : step;
            end else if (period_end) begin
                if (state == UP)        duty <= duty_up;
                else if (state == DOWN) duty <= duty_down;
            end
        end
    end

`ifdef PWM_FADE_HOLD_EN
    // The hold length is captured on entry so later changes only affect the next hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if ((state == UP && state_next == HOLD_HI) ||
                     (state == DOWN && state_next == HOLD_LO)) begin
            hold_cnt <= hold_periods;
        end else if ((state == HOLD_HI || state == HOLD_LO) && period_end && hold_cnt != '0) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: per-cycle check against a segment-list model.
module tb_pwm_fade_ctrl;

    localparam int MAXD = 255;

    logic       clk;
    logic       rst_n;
    logic [7:0] cnt;
    logic       start;
    logic       stop;
    logic       loop;
    logic [7:0] step;
    logic [7:0] hold_periods;
    logic       pwm_out;
    logic [7:0] duty;
    logic       busy;
    logic       cycle_done;

    int compared   = 0;
    int mismatched = 0;

    pwm_fade_ctrl #(.DUTY_MAX(8'hFF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cnt          (cnt),
        .start        (start),
        .stop         (stop),
        .loop         (loop),
        .step         (step),
        .hold_periods (hold_periods),
        .pwm_out      (pwm_out),
        .duty         (duty),
        .busy         (busy),
        .cycle_done   (cycle_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cnt = 8'($urandom_range(0, 255));
        forever begin
            @(posedge clk);
            #1 cnt = cnt + 8'd1;
        end
    end

    // Model: the duties still to be applied at upcoming period ends, one entry per period.
    int mDuty  = 0;
    int mStep  = 1;
    int phase  = 0;
    bit mBusy  = 1'b0;
    bit mDone  = 1'b0;
    bit mPwm   = 1'b0;
    int plan[$];

    function automatic void pushRamp(input bit rising);
        int v;
        v = rising ? 0 : MAXD;
        do begin
            if (rising) v = (v + mStep > MAXD) ? MAXD : v + mStep;
            else        v = (v - mStep < 0) ? 0 : v - mStep;
            plan.push_back(v);
        end while (v != (rising ? MAXD : 0));
    endfunction

    function automatic void pushHold(input int level);
        for (int i = 0; i <= int'(hold_periods); i++) plan.push_back(level);
    endfunction

    function automatic void endCycle();
        mDone = 1'b1;
        if (loop) begin
            pushRamp(1'b1);
            phase = 0;
        end else begin
            mBusy = 1'b0;
        end
    endfunction

    function automatic void nextSegment();
`ifdef PWM_FADE_HOLD_EN
        case (phase)
            0:       begin pushHold(MAXD); phase = 1; end
            1:       begin pushRamp(1'b0); phase = 2; end
            2:       begin pushHold(0);    phase = 3; end
            default: endCycle();
        endcase
`else
        if (phase == 0) begin
            pushRamp(1'b0);
            phase = 2;
        end else begin
            endCycle();
        end
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mDuty = 0;
            mStep = 1;
            mBusy = 1'b0;
            mDone = 1'b0;
            mPwm  = 1'b0;
            plan.delete();
        end else begin
            mPwm  = (int'(cnt) < mDuty);
            mDone = 1'b0;
            if (stop) begin
                mBusy = 1'b0;
                mDuty = 0;
                plan.delete();
            end else if (!mBusy) begin
                if (start) begin
                    mBusy = 1'b1;
                    mStep = (step == 8'd0) ? 1 : int'(step);
                    phase = 0;
                    pushRamp(1'b1);
                end
            end else if (cnt == 8'hFF) begin
                mDuty = plan.pop_front();
                if (plan.size() == 0) nextSegment();
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("duty", int'(duty), mDuty);
        checkOutput("busy", int'(busy), int'(mBusy));
        checkOutput("cycle_done", int'(cycle_done), int'(mDone));
        checkOutput("pwm_out", int'(pwm_out), int'(mPwm));
    end

    // Duty seen on the first cycle of every period while recording is on.
    bit recOn = 1'b0;
    int recQ[$];

    always @(negedge clk) begin
        if (recOn && cnt == 8'h00) recQ.push_back(int'(duty));
    end

    task automatic applyStimulus(input bit s, input bit p, input bit l,
                                 input logic [7:0] st, input logic [7:0] hp);
        @(posedge clk);
        #1;
        start        = s;
        stop         = p;
        loop         = l;
        step         = st;
        hold_periods = hp;
    endtask

    task automatic pulseStart(input bit l, input logic [7:0] st, input logic [7:0] hp);
        applyStimulus(1'b1, 1'b0, l, st, hp);
        applyStimulus(1'b0, 1'b0, l, st, hp);
    endtask

    task automatic waitCnt(input logic [7:0] v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cnt != v && n < 300);
        if (cnt != v) checkOutput("cntWaitTimeout", int'(cnt), int'(v));
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cycle_done !== 1'b1 && n < budget);
        if (cycle_done !== 1'b1) checkOutput("cycleDoneTimeout", 0, 1);
    endtask

    task automatic recordCycle(input logic [7:0] st, input logic [7:0] hp);
        recQ.delete();
        waitCnt(8'd10);
        pulseStart(1'b0, st, hp);
        recOn = 1'b1;
        waitDone(40 * 256);
        @(negedge clk);
        recOn = 1'b0;
    endtask

    initial begin
        int expA[$];
        int hiCount;
        int loCount;
        int doneCount;
        int n;

        start        = 1'b0;
        stop         = 1'b0;
        loop         = 1'b0;
        step         = 8'd1;
        hold_periods = 8'd0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n     = 1'b1;
        @(negedge clk);
        checkOutput("resetBusy", int'(busy), 0);
        checkOutput("resetDuty", int'(duty), 0);

        // Single up/down cycle, step 51, no extra hold periods.
        recordCycle(8'd51, 8'd0);
`ifdef PWM_FADE_HOLD_EN
        expA = '{51, 102, 153, 204, 255, 255, 204, 153, 102, 51, 0, 0};
`else
        expA = '{51, 102, 153, 204, 255, 204, 153, 102, 51, 0};
`endif
        checkOutput("rampLength", recQ.size(), expA.size());
        foreach (expA[i]) begin
            if (i < recQ.size()) checkOutput($sformatf("ramp[%0d]", i), recQ[i], expA[i]);
        end
        checkOutput("busyAfterOneShot", int'(busy), 0);

        // step 0 behaves as step 1.
        waitCnt(8'd10);
        pulseStart(1'b0, 8'd0, 8'd0);
        for (int k = 0; k < 10; k++) waitCnt(8'd0);
        checkOutput("step0Duty", int'(duty), 10);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

        // Three extra hold periods at top and bottom.
        recordCycle(8'd51, 8'd3);
        hiCount = 0;
        loCount = 0;
        foreach (recQ[i]) begin
            if (recQ[i] == 255) hiCount++;
            if (recQ[i] == 0)   loCount++;
        end
`ifdef PWM_FADE_HOLD_EN
        checkOutput("topPeriods", hiCount, 5);
        checkOutput("bottomPeriods", loCount, 5);
`else
        checkOutput("topPeriods", hiCount, 1);
        checkOutput("bottomPeriods", loCount, 1);
`endif

        // Asynchronous reset in the middle of a ramp.
        pulseStart(1'b1, 8'd51, 8'd0);
        n = 0;
        while (duty != 8'd153 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachDuty153", int'(duty), 153);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midResetDuty", int'(duty), 0);
        checkOutput("midResetBusy", int'(busy), 0);
        checkOutput("midResetPwm", int'(pwm_out), 0);
        checkOutput("midResetDone", int'(cycle_done), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Start after reset, then stop and start together while ramping.
        pulseStart(1'b1, 8'd85, 8'd1);
        for (int k = 0; k < 3; k++) waitCnt(8'd0);
        waitCnt(8'd50);
        checkOutput("pwmHighBeforeStop", int'(pwm_out), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'd85, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd85, 8'd1);
        checkOutput("stopWinsBusy", int'(busy), 0);
        checkOutput("stopWinsDuty", int'(duty), 0);
        @(posedge clk);
        #1;
        checkOutput("stopPwmLow", int'(pwm_out), 0);
        pulseStart(1'b1, 8'd85, 8'd1);
        doneCount = 0;
        for (int k = 0; k < 2; k++) begin
            waitDone(30 * 256);
            if (cycle_done === 1'b1) doneCount++;
        end
        checkOutput("loopDoneCount", doneCount, 2);
        checkOutput("loopStillBusy", int'(busy), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd85, 8'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd85, 8'd1);

        // Randomized control traffic; the per-cycle compare does the checking.
        for (int c = 0; c < 25000; c++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 3999) == 0),
                          ($urandom_range(0, 3) != 0),
                          8'($urandom_range(16, 255)),
                          8'($urandom_range(0, 3)));
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd1, 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd1, 8'd0);
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
